impulse_memory_server: RTL and testbench
========================================

IMPULSE_MEMORY_SERVER -- requirements
Module: impulse_memory_server

Interface
REQ-001: Parameter IMPULSE_LENGTH, 24000, number of 16-bit IR taps held; SHALL be a multiple of 8.
REQ-002: Parameter ROWS, IMPULSE_LENGTH/8 (3000), number of 8-tap rows; derived, not overridden.
REQ-003: audio_clk  input  1  sole clock, 98.3 MHz; all logic SHALL be on its rising edge.
REQ-004: rst_in_n  input  1  reset, asynchronous assert, active-low.
REQ-005: ir_load_start  input  1  one-cycle pulse; begins or restarts an IR load.
REQ-006: ir_sample_in  input  16 signed  IR tap, in tap order 0..IMPULSE_LENGTH-1.
REQ-007: ir_sample_valid  input  1  ir_sample_in valid this cycle.
REQ-008: first_ir_index  input  12  row address for read port A.
REQ-009: second_ir_index  input  12  row address for read port B.
REQ-010: ir_vals  output  8x16 signed  row at first_ir_index; element [k] = tap 8*row+k.
REQ-011: ir_vals_second  output  8x16 signed  row at second_ir_index, same packing.
REQ-012: impulse_in_memory_complete  output  1  all ROWS rows stored, reads valid.
REQ-013: ir_rows_loaded  output  12  count of rows committed in current load.
REQ-014: ir_overflow  output  1  sticky; sample offered while in DONE.

Function
REQ-015: FSM states IDLE, LOADING, DONE; SHALL reset to IDLE.
REQ-016: IDLE -> LOADING on ir_load_start; LOADING -> DONE in the cycle after row ROWS-1 is committed; DONE -> LOADING on ir_load_start; LOADING -> LOADING (counters cleared) on ir_load_start.
REQ-017: In LOADING, each ir_sample_valid cycle SHALL write ir_sample_in into lane tap_count[2:0] of an 8-lane packing register and increment tap_count (3 bits, wraps 7 -> 0).
REQ-018: On the 8th tap (tap_count==7 with valid), the packed row including that tap SHALL be written to row ir_rows_loaded next cycle, and ir_rows_loaded SHALL increment by 1.
REQ-019: impulse_in_memory_complete SHALL be 1 exactly when state is DONE; it SHALL drop in the cycle after ir_load_start is sampled.
REQ-020: ir_load_start together with ir_sample_valid in the same cycle: start wins, sample discarded, tap_count and ir_rows_loaded cleared to 0.
REQ-021: ir_sample_valid in IDLE SHALL be ignored with no flag; in DONE SHALL be ignored and SHALL set ir_overflow; ir_overflow SHALL clear only on ir_load_start or reset.
REQ-022: Read ports: index registered at edge N, row data registered at edge N+1; latency 2 cycles from index change to ir_vals/ir_vals_second update; both ports independent and may address the same row.
REQ-023: A read with index >= ROWS, or while state is not DONE, SHALL return all-zero lanes at the same 2-cycle latency.
REQ-024: Storage SHALL be inferable as simple dual-read block RAM (one write port, two read ports); contents SHALL NOT be cleared by reset or ir_load_start.
REQ-025: Samples SHALL be stored bit-exact; no scaling, saturation or sign change.

Reset
REQ-026: On rst_in_n low, asynchronously: state IDLE, tap_count 0, ir_rows_loaded 0, impulse_in_memory_complete 0, ir_overflow 0, ir_vals 0, ir_vals_second 0, read pipeline registers 0.
REQ-027: Reset asserted mid-load SHALL abandon the partial row; a new ir_load_start is required before any read returns nonzero data.
REQ-028: Release of rst_in_n SHALL be synchronised to audio_clk internally before the FSM observes it.

Verification
REQ-029: Load start, then 24000 valid samples of value i[15:0] (tap index) -> complete rises the cycle after the 24000th tap commits; ir_rows_loaded==3000; first_ir_index=5 -> two cycles later ir_vals lanes = 40..47.
REQ-030: Load all taps = 16'sd1000 with gaps (valid every 3rd cycle) -> complete asserted; both ports indexes 0 and 2999 -> every lane 1000.
REQ-031: Read index 3000 and 4095 in DONE, and index 0 during LOADING -> all lanes 0 at 2-cycle latency.
REQ-032: Load 13 taps, assert ir_load_start with valid high -> ir_rows_loaded 0, tap_count 0, that sample discarded; subsequent full load gives correct row 0 (taps from the restart only).
REQ-033: After complete, drive 1 extra valid sample -> ir_overflow 1, memory unchanged (row 2999 still correct), complete stays 1; ir_load_start clears ir_overflow and drops complete next cycle.
REQ-034: Assert rst_in_n low after 500 taps -> all outputs 0 immediately (asynchronously, without waiting for a clock edge); reads return 0 until a fresh full load completes.

Source files
------------

// File: rtl/impulse_memory_server.sv
// Impulse-response tap store. Serial 16-bit taps are packed eight at a time
// into rows of a one-write / two-read memory. Two independent read ports
// return whole rows with a fixed two-cycle latency once a full load completes.
module impulse_memory_server #(
    parameter int  IMPULSE_LENGTH = 24000,
    localparam int ROWS           = IMPULSE_LENGTH / 8
) (
    input  logic               audio_clk,
    input  logic               rst_in_n,
    input  logic               ir_load_start,
    input  logic signed [15:0] ir_sample_in,
    input  logic               ir_sample_valid,
    input  logic [11:0]        first_ir_index,
    input  logic [11:0]        second_ir_index,
    output logic [7:0][15:0]   ir_vals,
    output logic [7:0][15:0]   ir_vals_second,
    output logic               impulse_in_memory_complete,
    output logic [11:0]        ir_rows_loaded,
    output logic               ir_overflow
);

    localparam int          AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [11:0] ROWS_W   = 12'(ROWS);
    localparam logic [11:0] LAST_ROW = 12'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, LOADING, DONE} state_t;

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_n;
    state_t            state_q, state_d;
    logic [2:0]        tap_q, tap_d;
    logic [11:0]       rows_q, rows_d;
    logic              ovf_q, ovf_d;
    logic              wr_pend_q, wr_pend_d;
    logic [7:0][15:0]  pack_q, pack_d;
    logic [7:0][15:0]  wr_row_q, wr_row_d;
    logic              commit;
    logic              complete;
    logic [AW-1:0]     idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic              ok_a_q, ok_a_d, ok_b_q, ok_b_d;
    logic [7:0][15:0]  vals_a_q, vals_b_q;
    logic [7:0][15:0]  mem [ROWS];

    // Reset release is brought onto audio_clk; assertion stays asynchronous.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Two-flop reset synchroniser.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // FSM state register.
    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a start pulse always (re)enters LOADING; the last row commit ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ir_load_start) state_d = LOADING;
            LOADING: begin
                if (ir_load_start)                        state_d = LOADING;
                else if (commit && (rows_q == LAST_ROW))  state_d = DONE;
            end
            DONE:    if (ir_load_start) state_d = LOADING;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: row commit strobe (cancelled by a restart) and completion flag.
    always_comb begin
        commit   = (state_q == LOADING) && wr_pend_q && !ir_load_start;
        complete = (state_q == DONE);
    end

    // Tap packing, row counting and overflow tracking.
    always_comb begin
        tap_d     = tap_q;
        rows_d    = rows_q;
        ovf_d     = ovf_q;
        pack_d    = pack_q;
        wr_pend_d = 1'b0;
        wr_row_d  = wr_row_q;
        if (ir_load_start) begin
            tap_d  = 3'd0;
            rows_d = 12'd0;
            ovf_d  = 1'b0;
        end else begin
            if (commit) rows_d = rows_q + 12'd1;
            if ((state_q == LOADING) && ir_sample_valid) begin
                pack_d[tap_q] = ir_sample_in;
                tap_d         = tap_q + 3'd1;
                if (tap_q == 3'd7) begin
                    wr_pend_d = 1'b1;
                    wr_row_d  = pack_d;
                end
            end
            if ((state_q == DONE) && ir_sample_valid) ovf_d = 1'b1;
        end
    end

    // Control registers; a reset drops any pending partial row.
    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q     <= 3'd0;
            rows_q    <= 12'd0;
            ovf_q     <= 1'b0;
            wr_pend_q <= 1'b0;
        end else begin
            tap_q     <= tap_d;
            rows_q    <= rows_d;
            ovf_q     <= ovf_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    // Packing and write-data registers carry data only and need no reset.
    always_ff @(posedge audio_clk) begin
        pack_q   <= pack_d;
        wr_row_q <= wr_row_d;
    end

    // Single write port; contents survive reset and restarts.
    always_ff @(posedge audio_clk) begin
        if (commit) mem[rows_q[AW-1:0]] <= wr_row_q;
    end

    // Read address stage: range and state are qualified once, when the index is captured.
    always_comb begin
        idx_a_d = first_ir_index[AW-1:0];
        idx_b_d = second_ir_index[AW-1:0];
        ok_a_d  = (state_q == DONE) && (first_ir_index < ROWS_W);
        ok_b_d  = (state_q == DONE) && (second_ir_index < ROWS_W);
    end

    // Read pipeline: index captured on one edge, row data on the next.
    always_ff @(posedge audio_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            ok_a_q   <= 1'b0;
            ok_b_q   <= 1'b0;
            vals_a_q <= '0;
            vals_b_q <= '0;
        end else begin
            idx_a_q  <= idx_a_d;
            idx_b_q  <= idx_b_d;
            ok_a_q   <= ok_a_d;
            ok_b_q   <= ok_b_d;
            vals_a_q <= ok_a_q ? mem[idx_a_q] : '0;
            vals_b_q <= ok_b_q ? mem[idx_b_q] : '0;
        end
    end

    assign ir_vals                    = vals_a_q;
    assign ir_vals_second             = vals_b_q;
    assign impulse_in_memory_complete = complete;
    assign ir_rows_loaded             = rows_q;
    assign ir_overflow                = ovf_q;

endmodule

// File: tb/tb_impulse_memory_server.sv
// Bench for impulse_memory_server: directed load sequences, a read-vector
// table and randomized loads/reads compared against a tap-array model.
module tb_impulse_memory_server;

    localparam int IL   = 2400;
    localparam int ROWS = IL / 8;

    logic              audio_clk = 1'b0;
    logic              rst_in_n;
    logic              ir_load_start;
    logic signed [15:0] ir_sample_in;
    logic              ir_sample_valid;
    logic [11:0]       first_ir_index;
    logic [11:0]       second_ir_index;
    logic [7:0][15:0]  ir_vals;
    logic [7:0][15:0]  ir_vals_second;
    logic              impulse_in_memory_complete;
    logic [11:0]       ir_rows_loaded;
    logic              ir_overflow;

    always #5 audio_clk = ~audio_clk;

    impulse_memory_server #(.IMPULSE_LENGTH(IL)) dut (
        .audio_clk                  (audio_clk),
        .rst_in_n                   (rst_in_n),
        .ir_load_start              (ir_load_start),
        .ir_sample_in               (ir_sample_in),
        .ir_sample_valid            (ir_sample_valid),
        .first_ir_index             (first_ir_index),
        .second_ir_index            (second_ir_index),
        .ir_vals                    (ir_vals),
        .ir_vals_second             (ir_vals_second),
        .impulse_in_memory_complete (impulse_in_memory_complete),
        .ir_rows_loaded             (ir_rows_loaded),
        .ir_overflow                (ir_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: taps of the last completed load, and whether reads are live.
    logic [15:0] ref_taps [IL];
    bit          model_done = 1'b0;

    typedef struct {
        logic [11:0]  a;
        logic [11:0]  b;
        logic [127:0] ea;
        logic [127:0] eb;
    } rd_vec_t;

    rd_vec_t tbl [8];

    function automatic logic [127:0] model_row(input int r);
        logic [127:0] v = '0;
        if (model_done && r >= 0 && r < ROWS)
            for (int k = 0; k < 8; k++) v[16*k +: 16] = ref_taps[8*r + k];
        return v;
    endfunction

    function automatic logic [127:0] ramp_row(input int r);
        logic [127:0] v = '0;
        if (r >= 0 && r < ROWS)
            for (int k = 0; k < 8; k++) v[16*k +: 16] = 16'(8*r + k);
        return v;
    endfunction

    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [11:0] b,
                      input logic [127:0] ea, input logic [127:0] eb);
        first_ir_index  = a;
        second_ir_index = b;
        tick();
        tick();
        check({name, "_a"}, ir_vals, ea);
        check({name, "_b"}, ir_vals_second, eb);
    endtask

    task automatic rd_model(input string name, input int a, input int b);
        rd(name, 12'(a), 12'(b), model_row(a), model_row(b));
    endtask

    // mode: 0 ramp i[15:0], 1 constant 1000, 2 random. gap: 0 none, 1 every 3rd cycle, 2 random.
    task automatic load_ir(input int mode, input int gap, input bit do_start);
        logic [15:0] v;
        int idle;
        if (do_start) begin
            ir_load_start = 1'b1;
            tick();
            ir_load_start = 1'b0;
        end
        model_done = 1'b0;
        for (int i = 0; i < IL; i++) begin
            idle = (gap == 1) ? 2 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (idle) tick();
            case (mode)
                0:       v = 16'(i);
                1:       v = 16'd1000;
                default: v = 16'($urandom);
            endcase
            ir_sample_in    = v;
            ir_sample_valid = 1'b1;
            tick();
            ir_sample_valid = 1'b0;
            ref_taps[i]     = v;
        end
        check("rows_before_last_commit", 128'(ir_rows_loaded), 128'(ROWS - 1));
        check("complete_before_last_commit", 128'(impulse_in_memory_complete), 128'(0));
        tick();
        check("rows_after_load", 128'(ir_rows_loaded), 128'(ROWS));
        check("complete_after_load", 128'(impulse_in_memory_complete), 128'(1));
        check("overflow_after_load", 128'(ir_overflow), 128'(0));
        model_done = 1'b1;
    endtask

    task automatic async_reset_check(input string tag);
        rst_in_n = 1'b0;
        #1;
        check({tag, "_complete"}, 128'(impulse_in_memory_complete), 128'(0));
        check({tag, "_rows"}, 128'(ir_rows_loaded), 128'(0));
        check({tag, "_overflow"}, 128'(ir_overflow), 128'(0));
        check({tag, "_vals"}, ir_vals, 128'(0));
        check({tag, "_vals_second"}, ir_vals_second, 128'(0));
        model_done = 1'b0;
    endtask

    task automatic release_reset();
        tick();
        rst_in_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst_in_n        = 1'b0;
        ir_load_start   = 1'b0;
        ir_sample_in    = '0;
        ir_sample_valid = 1'b0;
        first_ir_index  = '0;
        second_ir_index = '0;

        // Reset state
        repeat (3) tick();
        check("reset_complete", 128'(impulse_in_memory_complete), 128'(0));
        check("reset_rows", 128'(ir_rows_loaded), 128'(0));
        check("reset_overflow", 128'(ir_overflow), 128'(0));
        check("reset_vals", ir_vals, 128'(0));
        check("reset_vals_second", ir_vals_second, 128'(0));
        release_reset();

        // Samples in IDLE are ignored without a flag
        ir_sample_in    = 16'sd5;
        ir_sample_valid = 1'b1;
        tick();
        ir_sample_valid = 1'b0;
        tick();
        check("idle_sample_overflow", 128'(ir_overflow), 128'(0));
        check("idle_sample_rows", 128'(ir_rows_loaded), 128'(0));
        rd("idle_read", 12'd0, 12'd1, '0, '0);

        // Ramp load, then the read-vector table
        load_ir(0, 0, 1'b1);
        tbl[0] = '{a: 12'd5,    b: 12'd5,    ea: ramp_row(5),   eb: ramp_row(5)};
        tbl[1] = '{a: 12'd0,    b: 12'(ROWS-1), ea: ramp_row(0), eb: ramp_row(ROWS-1)};
        tbl[2] = '{a: 12'd1,    b: 12'(ROWS-2), ea: ramp_row(1), eb: ramp_row(ROWS-2)};
        tbl[3] = '{a: 12'd150,  b: 12'd0,    ea: ramp_row(150), eb: ramp_row(0)};
        tbl[4] = '{a: 12'(ROWS), b: 12'd5,   ea: '0,            eb: ramp_row(5)};
        tbl[5] = '{a: 12'd4095, b: 12'(ROWS), ea: '0,           eb: '0};
        tbl[6] = '{a: 12'(ROWS-1), b: 12'(ROWS-1), ea: ramp_row(ROWS-1), eb: ramp_row(ROWS-1)};
        tbl[7] = '{a: 12'd37,   b: 12'd4095, ea: ramp_row(37),  eb: '0};
        for (int i = 0; i < 8; i++)
            rd($sformatf("ramp_tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb);

        // Constant 1000, one valid every third cycle
        load_ir(1, 1, 1'b1);
        rd("const_0_last", 12'd0, 12'(ROWS-1), {8{16'd1000}}, {8{16'd1000}});
        rd("const_last_0", 12'(ROWS-1), 12'd0, {8{16'd1000}}, {8{16'd1000}});

        // Reads during LOADING are zero; restart with a coincident sample
        first_ir_index  = 12'd0;
        second_ir_index = 12'd1;
        ir_load_start   = 1'b1;
        tick();
        ir_load_start   = 1'b0;
        model_done      = 1'b0;
        for (int i = 0; i < 13; i++) begin
            ir_sample_in    = 16'(100 + i);
            ir_sample_valid = 1'b1;
            tick();
        end
        ir_sample_valid = 1'b0;
        tick();
        check("loading_read_a", ir_vals, 128'(0));
        check("loading_read_b", ir_vals_second, 128'(0));
        check("partial_rows", 128'(ir_rows_loaded), 128'(1));
        ir_load_start   = 1'b1;
        ir_sample_valid = 1'b1;
        ir_sample_in    = 16'sh7777;
        tick();
        ir_load_start   = 1'b0;
        ir_sample_valid = 1'b0;
        check("restart_rows", 128'(ir_rows_loaded), 128'(0));
        check("restart_complete", 128'(impulse_in_memory_complete), 128'(0));
        load_ir(2, 2, 1'b0);
        rd_model("restart_row0", 0, 1);
        for (int i = 0; i < 20; i++)
            rd_model($sformatf("rand_rd%0d", i),
                     int'($urandom_range(0, ROWS + 40)), int'($urandom_range(0, ROWS + 40)));

        // Extra sample in DONE sets overflow, memory untouched
        ir_sample_in    = 16'sh5A5A;
        ir_sample_valid = 1'b1;
        tick();
        ir_sample_valid = 1'b0;
        check("overflow_set", 128'(ir_overflow), 128'(1));
        check("overflow_complete", 128'(impulse_in_memory_complete), 128'(1));
        rd_model("overflow_last_row", ROWS - 1, ROWS - 2);
        check("overflow_sticky", 128'(ir_overflow), 128'(1));
        ir_load_start = 1'b1;
        tick();
        ir_load_start = 1'b0;
        model_done    = 1'b0;
        check("start_clears_overflow", 128'(ir_overflow), 128'(0));
        check("start_drops_complete", 128'(impulse_in_memory_complete), 128'(0));

        // Asynchronous reset after 500 taps
        for (int i = 0; i < 500; i++) begin
            ir_sample_in    = 16'($urandom);
            ir_sample_valid = 1'b1;
            tick();
        end
        ir_sample_valid = 1'b0;
        check("rows_at_500", 128'(ir_rows_loaded), 128'(62));
        async_reset_check("midload_reset");
        release_reset();
        rd("after_reset_read", 12'd5, 12'd0, '0, '0);

        // Fresh load after reset, then asynchronous reset in DONE
        load_ir(0, 0, 1'b1);
        rd_model("fresh_load", 5, ROWS - 1);
        async_reset_check("done_reset");
        release_reset();
        rd("done_reset_read", 12'd5, 12'(ROWS - 1), '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
